vlsu_meta_buffer: RTL and testbench
===================================

// Module: vlsu_meta_buffer
// PURPOSE
//   Circular FIFO that decouples the control machine's meta output from the data controller.
//   Each entry holds one (meta_glb, meta_seglv) pair.
//   Upstream drives meta_ctrl_valid and consumes meta_ctrl_ready; the control machine derives
//   its buffer-full flag as !ready. The data controller pops the head entry when it starts
//   a new segment.
//   Registered storage: no combinational path from enq inputs to deq outputs.
// PARAMETERS
//   Depth        4      number of entries; legal range >= 2, any integer (need not be 2^n)
//   meta_glb_t   logic  per-request global meta type (vlsu_pkg)
//   meta_seglv_t logic  per-segment meta type (vlsu_pkg)
//   CntW         $clog2(Depth+1)  derived; occupancy counter width
// PORTS
//   clk_i          in   1                      clock
//   rst_ni         in   1                      asynchronous active-low reset
//   enq_valid_i    in   1                      upstream has an entry (meta_ctrl_valid)
//   enq_ready_o    out  1                      buffer not full (meta_ctrl_ready)
//   enq_glb_i      in   $bits(meta_glb_t)      global meta to store
//   enq_seglv_i    in   $bits(meta_seglv_t)    segment meta to store
//   deq_valid_o    out  1                      head entry present
//   deq_ready_i    in   1                      data controller takes head
//   deq_glb_o      out  $bits(meta_glb_t)      head global meta
//   deq_seglv_o    out  $bits(meta_seglv_t)    head segment meta
//   count_o        out  CntW                   current occupancy, 0..Depth
//   empty_o        out  1                      count_o == 0
// BEHAVIOUR
//   Reset (async, rst_ni=0)
//     - wr_ptr=0, rd_ptr=0, count=0.
//     - Outputs: enq_ready_o=1, deq_valid_o=0, empty_o=1, count_o=0.
//     - deq_glb_o/deq_seglv_o=0; storage array is not reset.
//   Mid-operation reset discards all entries; first enq after release lands in slot 0.
//   enq_ready_o = (count != Depth).
//     - Depends only on registered count, never on deq_ready_i: a full buffer refuses enq
//       even in a pop cycle.
//   deq_valid_o = (count != 0); deq data = mem[rd_ptr] read combinationally from registers.
//   Enqueue fire (enq_valid_i & enq_ready_o) at edge:
//     - mem[wr_ptr] <= {enq_glb_i, enq_seglv_i}
//     - wr_ptr <= (wr_ptr==Depth-1) ? 0 : wr_ptr+1
//   Dequeue fire (deq_valid_o & deq_ready_i) at edge:
//     - rd_ptr advances with the same wrap rule.
//   Count update:
//     - +1 on enq only, -1 on deq only.
//     - Unchanged on simultaneous enq+deq, or when neither fires.
//   Latency
//     - Enq in cycle N is visible at deq in cycle N+1.
//     - No fall-through when empty; no bypass.
//   Simultaneous enq+deq with 0<count<Depth: both fire; pointers both move; data ordering
//   is preserved.
//   Empty + enq_valid: deq_valid_o stays 0 this cycle and goes 1 next cycle.
//   Full + deq: enq_ready_o rises the cycle after the pop.
//   Protocol on the enq side:
//     - enq_valid_i with enq_ready_o=0 is ignored.
//     - Upstream must hold payload until accepted.
//   Protocol on the deq side:
//     - deq outputs stable while deq_valid_o=1 and deq_ready_i=0.
//   Assertions:
//     - count<=Depth at all times.
//     - No enq fire when full; no deq fire when empty.
//     - wr_ptr == (rd_ptr+count) mod Depth.
// TESTING
//   1. Reset mid-fill (count=2), release
//      -> count_o=0, deq_valid_o=0, enq_ready_o=1;
//      -> next enq of seglv=0xA appears at head one cycle later.
//   2. Depth=4, enq A,B,C,D back-to-back, deq_ready_i=0
//      -> enq_ready_o=0 after 4th accept, count_o=4;
//      -> 5th enq_valid_i ignored; drain yields A,B,C,D in order.
//   3. Full (4), assert enq_valid_i and deq_ready_i together
//      -> deq of A fires, enq not accepted;
//      -> next cycle count_o=3, enq_ready_o=1.
//   4. count=2, simultaneous enq+deq every cycle for 10 cycles
//      -> count_o constant 2; output sequence matches input sequence delayed by 2 pops.
//   5. Depth=3 (non-power-of-2), 7 enq/deq pairs
//      -> pointers wrap 2->0 correctly; data integrity holds; no X on deq outputs.
//   6. Random valid/ready at 50%, 10k cycles
//      -> scoreboard order match; assertions clean; deq payload stable while stalled.

Source files
------------

// File: rtl/vlsu_meta_buffer.sv
// +------------------------------------------------------------------------+
// | vlsu_meta_buffer: circular FIFO of (meta_glb, meta_seglv) pairs.       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module vlsu_meta_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter type         meta_glb_t   = logic,
  parameter type         meta_seglv_t = logic,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  meta_glb_t         enq_glb_i,
  input  meta_seglv_t       enq_seglv_i,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output meta_glb_t         deq_glb_o,
  output meta_seglv_t       deq_seglv_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_glb_w = $bits(meta_glb_t);
  localparam int unsigned c_seg_w = $bits(meta_seglv_t);
  localparam int unsigned c_ent_w = c_glb_w + c_seg_w;

  logic [c_ent_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_enq_fire;
  logic               w_deq_fire;
  logic [c_ptr_w-1:0] w_wr_ptr_nxt;
  logic [c_ptr_w-1:0] w_rd_ptr_nxt;
  logic [c_ent_w-1:0] w_head;

  // Readiness depends only on the registered count, so a full buffer refuses
  // an enqueue even while the head is being popped in the same cycle.
  assign enq_ready_o = (r_count != CNT_W'(DEPTH));
  assign deq_valid_o = (r_count != '0);
  assign empty_o     = (r_count == '0);
  assign count_o     = r_count;

  assign w_enq_fire  = enq_valid_i & enq_ready_o;
  assign w_deq_fire  = deq_valid_o & deq_ready_i;

  assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);

  // Storage is never reset; masking the head while empty keeps stale or
  // uninitialised contents off the outputs.
  assign w_head      = deq_valid_o ? r_mem[r_rd_ptr] : '0;
  assign deq_glb_o   = w_head[c_seg_w +: c_glb_w];
  assign deq_seglv_o = w_head[0 +: c_seg_w];

  always_ff @(posedge clk_i) begin
    if (w_enq_fire) begin
      r_mem[r_wr_ptr] <= {enq_glb_i, enq_seglv_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_deq_fire) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(r_count) <= DEPTH);
  a_no_enq_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_enq_fire |-> (32'(r_count) != DEPTH));
  a_no_deq_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_deq_fire |-> (r_count != '0));
  a_ptr_relation : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((32'(r_rd_ptr) + 32'(r_count)) % DEPTH) == 32'(r_wr_ptr));

endmodule

`default_nettype wire

// File: tb/tb_vlsu_meta_buffer.sv
// +------------------------------------------------------------------------+
// | tb_vlsu_meta_buffer: self-checking bench for vlsu_meta_buffer.          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_vlsu_meta_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       enq_valid4 = 0, enq_ready4, deq_valid4, deq_ready4 = 0, empty4;
  logic [7:0] enq_glb4 = 0, enq_seglv4 = 0, deq_glb4, deq_seglv4;
  logic [2:0] count4;
  logic       enq_valid3 = 0, enq_ready3, deq_valid3, deq_ready3 = 0, empty3;
  logic [7:0] enq_glb3 = 0, enq_seglv3 = 0, deq_glb3, deq_seglv3;
  logic [1:0] count3;

  vlsu_meta_buffer #(.DEPTH(4), .meta_glb_t(logic [7:0]), .meta_seglv_t(logic [7:0])) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .enq_valid_i(enq_valid4), .enq_ready_o(enq_ready4),
    .enq_glb_i(enq_glb4), .enq_seglv_i(enq_seglv4),
    .deq_valid_o(deq_valid4), .deq_ready_i(deq_ready4),
    .deq_glb_o(deq_glb4), .deq_seglv_o(deq_seglv4),
    .count_o(count4), .empty_o(empty4));

  vlsu_meta_buffer #(.DEPTH(3), .meta_glb_t(logic [7:0]), .meta_seglv_t(logic [7:0])) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .enq_valid_i(enq_valid3), .enq_ready_o(enq_ready3),
    .enq_glb_i(enq_glb3), .enq_seglv_i(enq_seglv3),
    .deq_valid_o(deq_valid3), .deq_ready_i(deq_ready3),
    .deq_glb_o(deq_glb3), .deq_seglv_o(deq_seglv3),
    .count_o(count3), .empty_o(empty3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue per instance, {glb, seglv} per entry.
  logic [15:0] q4[$];
  logic [15:0] q3[$];

  always @(posedge clk or negedge rst_n) begin : m4
    bit ef, df;
    if (!rst_n) q4.delete();
    else begin
      ef = enq_valid4 && (q4.size() < 4);
      df = deq_ready4 && (q4.size() > 0);
      if (df) void'(q4.pop_front());
      if (ef) q4.push_back({enq_glb4, enq_seglv4});
    end
  end

  always @(posedge clk or negedge rst_n) begin : m3
    bit ef, df;
    if (!rst_n) q3.delete();
    else begin
      ef = enq_valid3 && (q3.size() < 3);
      df = deq_ready3 && (q3.size() > 0);
      if (df) void'(q3.pop_front());
      if (ef) q3.push_back({enq_glb3, enq_seglv3});
    end
  end

  always @(negedge clk) begin : cmp
    check("d4_count", 32'(count4), q4.size());
    check("d4_enq_ready", 32'(enq_ready4), 32'(q4.size() < 4));
    check("d4_deq_valid", 32'(deq_valid4), 32'(q4.size() > 0));
    check("d4_empty", 32'(empty4), 32'(q4.size() == 0));
    if (q4.size() > 0) check("d4_head", {16'h0, deq_glb4, deq_seglv4}, {16'h0, q4[0]});
    check("d3_count", 32'(count3), q3.size());
    check("d3_enq_ready", 32'(enq_ready3), 32'(q3.size() < 3));
    check("d3_deq_valid", 32'(deq_valid3), 32'(q3.size() > 0));
    check("d3_empty", 32'(empty3), 32'(q3.size() == 0));
    if (q3.size() > 0) check("d3_head", {16'h0, deq_glb3, deq_seglv3}, {16'h0, q3[0]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] seq4, seq3;
    bit acc4, acc3;

    repeat (2) tick();
    check("reset_glb_zero", 32'(deq_glb4), 32'h0);
    check("reset_seglv_zero", 32'(deq_seglv4), 32'h0);
    rst_n = 1'b1;

    // Reset mid-fill, then first entry after release.
    enq_valid4 = 1; enq_glb4 = 8'h11; enq_seglv4 = 8'h01; tick();
    enq_seglv4 = 8'h02; tick();
    enq_valid4 = 0;
    @(negedge clk); check("t1_count2", 32'(count4), 32'd2);
    tick();
    rst_n = 1'b0; #2;
    check("t1_rst_count", 32'(count4), 32'd0);
    check("t1_rst_valid", 32'(deq_valid4), 32'd0);
    check("t1_rst_ready", 32'(enq_ready4), 32'd1);
    tick(); rst_n = 1'b1;
    enq_valid4 = 1; enq_glb4 = 8'hA0; enq_seglv4 = 8'h0A;
    @(negedge clk); check("t1_no_fallthrough", 32'(deq_valid4), 32'd0);
    tick(); enq_valid4 = 0;
    @(negedge clk);
    check("t1_head_valid", 32'(deq_valid4), 32'd1);
    check("t1_head_seglv", 32'(deq_seglv4), 32'h0A);
    deq_ready4 = 1; tick(); deq_ready4 = 0;

    // Fill to full, fifth offer ignored.
    for (int i = 0; i < 5; i++) begin
      enq_valid4 = 1; enq_glb4 = 8'h10 + 8'(i); enq_seglv4 = 8'h0A + 8'(i); tick();
    end
    @(negedge clk);
    check("t2_count_full", 32'(count4), 32'd4);
    check("t2_ready_low", 32'(enq_ready4), 32'd0);

    // Full with enq and deq together: only the pop fires.
    deq_ready4 = 1; tick();
    enq_valid4 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t3_count3", 32'(count4), 32'd3);
        check("t3_ready_back", 32'(enq_ready4), 32'd1);
      end
      check("t2_drain_order", 32'(deq_seglv4), 32'h0B + i);
    end
    tick(); deq_ready4 = 0;
    @(negedge clk); check("t2_drained", 32'(count4), 32'd0);

    // Steady occupancy 2 with simultaneous enq+deq.
    enq_valid4 = 1; enq_glb4 = 8'h55;
    enq_seglv4 = 8'h20; tick();
    enq_seglv4 = 8'h21; tick();
    deq_ready4 = 1;
    for (int i = 0; i < 10; i++) begin
      enq_seglv4 = 8'h22 + 8'(i);
      @(negedge clk);
      check("t4_count_const", 32'(count4), 32'd2);
      check("t4_delayed_seq", 32'(deq_seglv4), 32'h20 + i);
      tick();
    end
    enq_valid4 = 0; tick(); tick(); deq_ready4 = 0;

    // Depth 3: fill check, then wrapping pairs.
    enq_valid3 = 1; enq_glb3 = 8'h77;
    for (int i = 0; i < 3; i++) begin enq_seglv3 = 8'h40 + 8'(i); tick(); end
    enq_valid3 = 0;
    @(negedge clk);
    check("t5_full3", 32'(count3), 32'd3);
    check("t5_ready3_low", 32'(enq_ready3), 32'd0);
    deq_ready3 = 1; tick(); tick(); tick(); deq_ready3 = 0;
    enq_valid3 = 1; enq_seglv3 = 8'h30; tick();
    deq_ready3 = 1;
    for (int i = 0; i < 7; i++) begin
      enq_seglv3 = 8'h31 + 8'(i);
      @(negedge clk);
      check("t5_wrap_data", 32'(deq_seglv3), 32'h30 + i);
      check("t5_wrap_glb", 32'(deq_glb3), 32'h77);
      tick();
    end
    enq_valid3 = 0; tick(); deq_ready3 = 0;
    @(negedge clk); check("t5_empty3", 32'(empty3), 32'd1);

    // Random valid/ready; payload held until accepted.
    seq4 = 16'h1000; seq3 = 16'h2000;
    tick();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc4 = enq_valid4 && enq_ready4;
      acc3 = enq_valid3 && enq_ready3;
      tick();
      if (acc4) seq4++;
      if (acc3) seq3++;
      enq_valid4 = 1'($urandom_range(0, 1)); deq_ready4 = 1'($urandom_range(0, 1));
      enq_valid3 = 1'($urandom_range(0, 1)); deq_ready3 = 1'($urandom_range(0, 1));
      {enq_glb4, enq_seglv4} = seq4;
      {enq_glb3, enq_seglv3} = seq3;
    end
    enq_valid4 = 0; enq_valid3 = 0; deq_ready4 = 1; deq_ready3 = 1;
    repeat (5) tick();
    @(negedge clk);
    check("t6_final_empty4", 32'(empty4), 32'd1);
    check("t6_final_empty3", 32'(empty3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
